// File: rtl/space_ptr_mgr.sv
// rtl/space_ptr_mgr.sv - per-channel circular-buffer space allocator with write-pointer ownership
// Grants allocations against free space, accepts consumer read-pointer returns, flags illegal returns.
module space_ptr_mgr #(
  parameter int CHANNELS      = 4,
  parameter int SPACE_GLB_PTR = 10,
  parameter int LEN_W         = 6,
  parameter int AFULL_OFFSET  = 16,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [CH_W-1:0]                   ALLOC_CH,
  input  logic [LEN_W-1:0]                  ALLOC_LEN,
  input  logic                              ALLOC_VLD,
  output logic                              ALLOC_RDY,
  output logic [SPACE_GLB_PTR-1:0]          ALLOC_ADDR,
  input  logic [CHANNELS*SPACE_GLB_PTR-1:0] SPACE_GLB_RD_PTR,
  input  logic [CHANNELS-1:0]               SPACE_GLB_RD_PTR_VLD,
  output logic [CHANNELS*SPACE_GLB_PTR-1:0] SPACE_GLB_WR_PTR,
  output logic [CHANNELS*SPACE_GLB_PTR-1:0] FREE,
  output logic [CHANNELS-1:0]               AFULL,
  output logic [CHANNELS-1:0]               RD_ERR
);

  localparam int P                = SPACE_GLB_PTR;
  localparam int CMP_W            = ((P > LEN_W) ? P : LEN_W) + 1;
  localparam logic [P-1:0] CAP    = '1;
  localparam logic [31:0] AFULL_TH = 32'(AFULL_OFFSET);

  logic [P-1:0]          wr_q [CHANNELS];
  logic [P-1:0]          wr_d [CHANNELS];
  logic [P-1:0]          rd_q [CHANNELS];
  logic [P-1:0]          rd_d [CHANNELS];
  logic [CHANNELS-1:0]   err_q;
  logic [CHANNELS-1:0]   err_d;

  logic [P-1:0]          used     [CHANNELS];
  logic [P-1:0]          free_w   [CHANNELS];
  logic [P-1:0]          rd_in    [CHANNELS];
  logic [P-1:0]          new_used [CHANNELS];

  logic [P-1:0]          sel_free;
  logic [P-1:0]          sel_wr;
  logic                  sel_hit;
  logic                  grant;

  // One word is always held back, so used never reaches 2^P and full/empty stay distinct.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      used[c]     = wr_q[c] - rd_q[c];
      free_w[c]   = CAP - used[c];
      rd_in[c]    = SPACE_GLB_RD_PTR[c*P +: P];
      new_used[c] = wr_q[c] - rd_in[c];
    end
  end

  always_comb begin
    SPACE_GLB_WR_PTR = '0;
    FREE             = '0;
    AFULL            = '0;
    RD_ERR           = err_q;
    for (int c = 0; c < CHANNELS; c++) begin
      SPACE_GLB_WR_PTR[c*P +: P] = wr_q[c];
      FREE[c*P +: P]             = free_w[c];
      AFULL[c]                   = (32'(free_w[c]) < AFULL_TH);
    end
  end

  // Channel codes beyond CHANNELS-1 never match, so such requests are never ready.
  always_comb begin
    sel_hit  = 1'b0;
    sel_free = '0;
    sel_wr   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ALLOC_CH == CH_W'(c)) begin
        sel_hit  = 1'b1;
        sel_free = free_w[c];
        sel_wr   = wr_q[c];
      end
    end
    ALLOC_RDY  = sel_hit && (CMP_W'(sel_free) >= CMP_W'(ALLOC_LEN));
    ALLOC_ADDR = sel_wr;
    grant      = ALLOC_VLD && ALLOC_RDY;
  end

  // Read legality uses pre-grant wr, so a same-cycle grant cannot make a return look illegal.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wr_d[c]  = wr_q[c];
      rd_d[c]  = rd_q[c];
      err_d[c] = err_q[c];
      if (grant && (ALLOC_CH == CH_W'(c))) begin
        wr_d[c] = wr_q[c] + P'(ALLOC_LEN);
      end
      if (SPACE_GLB_RD_PTR_VLD[c]) begin
        if (new_used[c] <= used[c]) begin
          rd_d[c] = rd_in[c];
        end else begin
          err_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_q[c] <= '0;
        rd_q[c] <= '0;
      end
      err_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_q[c] <= wr_d[c];
        rd_q[c] <= rd_d[c];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_space_ptr_mgr.sv
// tb/tb_space_ptr_mgr.sv - directed self-checking bench for space_ptr_mgr
module tb_space_ptr_mgr;

  logic        clk;
  logic        reset;
  logic [1:0]  alloc_ch;
  logic [5:0]  alloc_len;
  logic        alloc_vld;
  logic        alloc_rdy;
  logic [9:0]  alloc_addr;
  logic [39:0] rd_ptr;
  logic [3:0]  rd_vld;
  logic [39:0] wr_ptr;
  logic [39:0] free;
  logic [3:0]  afull;
  logic [3:0]  rd_err;

  int total;
  int passed;

  space_ptr_mgr #(
    .CHANNELS(4), .SPACE_GLB_PTR(10), .LEN_W(6), .AFULL_OFFSET(16)
  ) dut (
    .CLK(clk),
    .RESET(reset),
    .ALLOC_CH(alloc_ch),
    .ALLOC_LEN(alloc_len),
    .ALLOC_VLD(alloc_vld),
    .ALLOC_RDY(alloc_rdy),
    .ALLOC_ADDR(alloc_addr),
    .SPACE_GLB_RD_PTR(rd_ptr),
    .SPACE_GLB_RD_PTR_VLD(rd_vld),
    .SPACE_GLB_WR_PTR(wr_ptr),
    .FREE(free),
    .AFULL(afull),
    .RD_ERR(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int wr_of(input int c);
    return int'(wr_ptr[c*10 +: 10]);
  endfunction

  function automatic int free_of(input int c);
    return int'(free[c*10 +: 10]);
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    alloc_vld = 1'b0;
    rd_vld    = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic alloc(input int ch, input int len);
    alloc_ch  = ch[1:0];
    alloc_len = len[5:0];
    alloc_vld = 1'b1;
    @(posedge clk); #1;
    alloc_vld = 1'b0;
  endtask

  task automatic advance_wr(input int ch, input int amount);
    int left;
    int n;
    left = amount;
    while (left > 0) begin
      n = (left > 63) ? 63 : left;
      alloc(ch, n);
      left -= n;
    end
  endtask

  task automatic set_rd(input int ch, input int val);
    logic [9:0] v;
    v = val[9:0];
    rd_ptr[ch*10 +: 10] = v;
    rd_vld[ch] = 1'b1;
    @(posedge clk); #1;
    rd_vld = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    alloc_ch  = 2'd0;
    alloc_len = 6'd63;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (wr_of(c) !== 0) $display("FAIL reset_wr ch%0d got %0d want 0", c, wr_of(c));
      else passed++;
      total++;
      if (free_of(c) !== 1023) $display("FAIL reset_free ch%0d got %0d want 1023", c, free_of(c));
      else passed++;
    end
    total++;
    if (afull !== 4'b0000) $display("FAIL reset_afull got %b want 0000", afull);
    else passed++;
    total++;
    if (rd_err !== 4'b0000) $display("FAIL reset_rd_err got %b want 0000", rd_err);
    else passed++;
    total++;
    if (alloc_rdy !== 1'b1) $display("FAIL reset_rdy_len63 got %b want 1", alloc_rdy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_ch  = 2'd1;
    alloc_len = 6'd0;
    alloc_vld = 1'b1;
    #1;
    total++;
    if (alloc_rdy !== 1'b1) $display("FAIL len0_rdy got %b want 1", alloc_rdy);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (wr_of(1) !== 0) $display("FAIL len0_wr got %0d want 0", wr_of(1));
    else passed++;
    alloc_len = 6'd20;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (alloc_addr !== 10'(i * 20)) $display("FAIL b2b_addr%0d got %0d want %0d", i, alloc_addr, i * 20);
      else passed++;
      total++;
      if (alloc_rdy !== 1'b1) $display("FAIL b2b_rdy%0d got %b want 1", i, alloc_rdy);
      else passed++;
      @(posedge clk); #1;
    end
    alloc_vld = 1'b0;
    #1;
    total++;
    if (wr_of(1) !== 60) $display("FAIL b2b_wr1 got %0d want 60", wr_of(1));
    else passed++;
    total++;
    if (free_of(1) !== 963) $display("FAIL b2b_free1 got %0d want 963", free_of(1));
    else passed++;
    for (int c = 0; c < 4; c++) begin
      if (c != 1) begin
        total++;
        if (wr_of(c) !== 0 || free_of(c) !== 1023)
          $display("FAIL b2b_other ch%0d got wr=%0d free=%0d want wr=0 free=1023", c, wr_of(c), free_of(c));
        else passed++;
      end
    end
  endtask

  task automatic test_afull_hold();
    do_reset();
    advance_wr(0, 1013);
    #1;
    total++;
    if (free_of(0) !== 10) $display("FAIL fill_free0 got %0d want 10", free_of(0));
    else passed++;
    total++;
    if (afull[0] !== 1'b1) $display("FAIL fill_afull0 got %b want 1", afull[0]);
    else passed++;
    alloc_ch  = 2'd0;
    alloc_len = 6'd11;
    alloc_vld = 1'b1;
    #1;
    total++;
    if (alloc_rdy !== 1'b0) $display("FAIL hold_rdy got %b want 0", alloc_rdy);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (wr_of(0) !== 1013) $display("FAIL hold_wr0 got %0d want 1013", wr_of(0));
    else passed++;
    rd_ptr[9:0] = 10'd5;
    rd_vld[0]   = 1'b1;
    #1;
    total++;
    if (alloc_rdy !== 1'b0) $display("FAIL hold_rdy_pre_return got %b want 0", alloc_rdy);
    else passed++;
    @(posedge clk); #1;
    rd_vld = '0;
    #1;
    total++;
    if (free_of(0) !== 15) $display("FAIL return_free0 got %0d want 15", free_of(0));
    else passed++;
    total++;
    if (alloc_rdy !== 1'b1) $display("FAIL return_rdy got %b want 1", alloc_rdy);
    else passed++;
    total++;
    if (wr_of(0) !== 1013) $display("FAIL return_wr0 got %0d want 1013", wr_of(0));
    else passed++;
    @(posedge clk); #1;
    alloc_vld = 1'b0;
    #1;
    total++;
    if (wr_of(0) !== 0) $display("FAIL grant_wr0 got %0d want 0", wr_of(0));
    else passed++;
    total++;
    if (free_of(0) !== 4) $display("FAIL grant_free0 got %0d want 4", free_of(0));
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    advance_wr(0, 1020);
    set_rd(0, 1000);
    alloc_ch  = 2'd0;
    alloc_len = 6'd10;
    alloc_vld = 1'b1;
    #1;
    total++;
    if (alloc_addr !== 10'd1020) $display("FAIL wrap_addr got %0d want 1020", alloc_addr);
    else passed++;
    @(posedge clk); #1;
    alloc_vld = 1'b0;
    #1;
    total++;
    if (wr_of(0) !== 6) $display("FAIL wrap_wr0 got %0d want 6", wr_of(0));
    else passed++;
    total++;
    if (free_of(0) !== 993) $display("FAIL wrap_free0 got %0d want 993", free_of(0));
    else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    advance_wr(2, 100);
    set_rd(2, 50);
    #1;
    total++;
    if (free_of(2) !== 973) $display("FAIL same_pre_free2 got %0d want 973", free_of(2));
    else passed++;
    alloc_ch     = 2'd2;
    alloc_len    = 6'd8;
    alloc_vld    = 1'b1;
    rd_ptr[29:20] = 10'd90;
    rd_vld[2]    = 1'b1;
    #1;
    total++;
    if (alloc_rdy !== 1'b1 || alloc_addr !== 10'd100)
      $display("FAIL same_rdy_addr got rdy=%b addr=%0d want rdy=1 addr=100", alloc_rdy, alloc_addr);
    else passed++;
    @(posedge clk); #1;
    alloc_vld = 1'b0;
    rd_vld    = '0;
    #1;
    total++;
    if (wr_of(2) !== 108) $display("FAIL same_wr2 got %0d want 108", wr_of(2));
    else passed++;
    total++;
    if (free_of(2) !== 1005) $display("FAIL same_free2 got %0d want 1005", free_of(2));
    else passed++;
    total++;
    if (rd_err !== 4'b0000) $display("FAIL same_rd_err got %b want 0000", rd_err);
    else passed++;
  endtask

  task automatic test_illegal_and_reset();
    do_reset();
    advance_wr(3, 100);
    set_rd(3, 50);
    set_rd(3, 50);
    #1;
    total++;
    if (rd_err[3] !== 1'b0 || free_of(3) !== 973)
      $display("FAIL equal_rd got err=%b free=%0d want err=0 free=973", rd_err[3], free_of(3));
    else passed++;
    set_rd(3, 120);
    #1;
    total++;
    if (free_of(3) !== 973) $display("FAIL illegal_free3 got %0d want 973", free_of(3));
    else passed++;
    total++;
    if (rd_err !== 4'b1000) $display("FAIL illegal_rd_err got %b want 1000", rd_err);
    else passed++;
    set_rd(3, 60);
    #1;
    total++;
    if (rd_err[3] !== 1'b1) $display("FAIL sticky_rd_err3 got %b want 1", rd_err[3]);
    else passed++;
    total++;
    if (free_of(3) !== 983) $display("FAIL post_err_free3 got %0d want 983", free_of(3));
    else passed++;
    alloc_ch      = 2'd1;
    alloc_len     = 6'd30;
    alloc_vld     = 1'b1;
    rd_ptr[39:30] = 10'd80;
    rd_vld[3]     = 1'b1;
    reset         = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    alloc_vld = 1'b0;
    rd_vld    = '0;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (wr_of(c) !== 0 || free_of(c) !== 1023)
        $display("FAIL midreset ch%0d got wr=%0d free=%0d want wr=0 free=1023", c, wr_of(c), free_of(c));
      else passed++;
    end
    total++;
    if (rd_err !== 4'b0000 || afull !== 4'b0000)
      $display("FAIL midreset_flags got err=%b afull=%b want 0000 0000", rd_err, afull);
    else passed++;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    alloc_ch  = '0;
    alloc_len = '0;
    alloc_vld = 1'b0;
    rd_ptr    = '0;
    rd_vld    = '0;
    test_reset();
    test_back_to_back();
    test_afull_hold();
    test_wrap();
    test_same_cycle();
    test_illegal_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
